// File: rtl/elevator_pkg.sv
// elevator_pkg: shared defaults, floor/delta types and controller states
// for the elevator scheduler.
package elevator_pkg;

    localparam int NUM_FLOORS_DEF = 4;
    localparam int FLOOR_W_DEF    = 2;

    typedef logic [FLOOR_W_DEF-1:0]        floor_t;
    typedef logic signed [FLOOR_W_DEF+1:0] delta_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_ACK,
        MOVING,
        DOOR_OPEN,
        FAULT
    } state_e;

endpackage

// File: rtl/elevator_scheduler_if.sv
// elevator_scheduler_if: keypad, door buttons, motor handshake and status
// bundle; master is the scheduler side, slave the environment side.
interface elevator_scheduler_if #(
    parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS_DEF,
    parameter int FLOOR_W    = elevator_pkg::FLOOR_W_DEF
) ();

    logic                  call_valid;
    logic [FLOOR_W-1:0]    call_floor;
    logic                  open_btn;
    logic                  close_btn;
    logic                  move_busy;
    logic                  move_start;
    logic [FLOOR_W+1:0]    move_delta;
    logic                  door_open;
    logic [FLOOR_W-1:0]    cur_floor;
    logic                  dir_up;
    logic [NUM_FLOORS-1:0] pending;
    logic                  fault;

    modport master (
        input  call_valid, call_floor, open_btn, close_btn, move_busy,
        output move_start, move_delta, door_open, cur_floor, dir_up,
        output pending, fault
    );

    modport slave (
        output call_valid, call_floor, open_btn, close_btn, move_busy,
        input  move_start, move_delta, door_open, cur_floor, dir_up,
        input  pending, fault
    );

endinterface

// File: rtl/elevator_scheduler_scan_target_sel.sv
// scan_target_sel: combinational SCAN pick of the next target floor
// from the pending mask, current floor and travel direction.
module scan_target_sel
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF,
    parameter int FLOOR_W    = FLOOR_W_DEF
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  dir_up,
    output logic [FLOOR_W-1:0]    target,
    output logic                  new_dir,
    output logic                  valid
);

    logic [FLOOR_W-1:0] w_above;
    logic [FLOOR_W-1:0] w_below;
    logic               w_has_above;
    logic               w_has_below;

    // Scan orders make the last hit the nearest one on each side.
    always_comb begin
        w_above     = '0;
        w_below     = '0;
        w_has_above = 1'b0;
        w_has_below = 1'b0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && i > int'(cur_floor)) begin
                w_above     = FLOOR_W'(i);
                w_has_above = 1'b1;
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && i < int'(cur_floor)) begin
                w_below     = FLOOR_W'(i);
                w_has_below = 1'b1;
            end
        end
    end

    always_comb begin
        valid   = w_has_above | w_has_below;
        target  = cur_floor;
        new_dir = dir_up;
        if (dir_up) begin
            if (w_has_above) begin
                target = w_above;
            end else if (w_has_below) begin
                target  = w_below;
                new_dir = 1'b0;
            end
        end else begin
            if (w_has_below) begin
                target = w_below;
            end else if (w_has_above) begin
                target  = w_above;
                new_dir = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: call latching, SCAN dispatch, motor handshake, door dwell.
// Build option ELEVATOR_ACK_TIMEOUT_EN adds a motor-ack timeout with sticky fault.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = NUM_FLOORS_DEF,
    parameter int FLOOR_W      = FLOOR_W_DEF,
    parameter int DWELL_CYCLES = 300_000_000
`ifdef ELEVATOR_ACK_TIMEOUT_EN
   ,parameter int ACK_TIMEOUT  = 1_000_000
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    elevator_scheduler_if.master bus
);

    localparam int            DW         = $clog2(DWELL_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);

    state_e                r_state;
    logic [FLOOR_W-1:0]    r_cur;
    logic [FLOOR_W-1:0]    r_target;
    logic                  r_dir;
    logic [NUM_FLOORS-1:0] r_pend;
    logic                  r_door;
    logic                  r_start;
    logic [FLOOR_W+1:0]    r_delta;
    logic [DW-1:0]         r_dwell;

    logic [FLOOR_W-1:0]    w_target;
    logic                  w_new_dir;
    logic                  w_valid;
    logic                  w_call_ok;
    logic                  w_reload;
    logic                  w_here;
    logic                  w_clr_en;
    logic [FLOOR_W-1:0]    w_clr_floor;
    logic [NUM_FLOORS-1:0] w_set;
    logic [NUM_FLOORS-1:0] w_clr;
    logic [FLOOR_W+1:0]    w_delta;

    scan_target_sel #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan (
        .pending   (r_pend),
        .cur_floor (r_cur),
        .dir_up    (r_dir),
        .target    (w_target),
        .new_dir   (w_new_dir),
        .valid     (w_valid)
    );

    assign w_delta = {2'b00, w_target} - {2'b00, r_cur};

    // A call to the open floor only extends the dwell; set beats clear.
    always_comb begin
        w_call_ok   = bus.call_valid && (int'(bus.call_floor) < NUM_FLOORS);
        w_reload    = w_call_ok && (r_state == DOOR_OPEN)
                      && (bus.call_floor == r_cur);
        w_here      = 1'b0;
        w_clr_floor = (r_state == MOVING) ? r_target : r_cur;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_here = w_here | (r_pend[i] && r_cur == FLOOR_W'(i));
        end
        w_clr_en = ((r_state == IDLE) && (bus.open_btn || w_here))
                   || ((r_state == MOVING) && !bus.move_busy);
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_set[i] = w_call_ok && !w_reload
                       && (bus.call_floor == FLOOR_W'(i));
            w_clr[i] = w_clr_en && (w_clr_floor == FLOOR_W'(i));
        end
    end

`ifdef ELEVATOR_ACK_TIMEOUT_EN
    localparam int            AW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);
    logic [AW-1:0] r_ack_cnt;
    logic          r_fault;
    assign bus.fault = r_fault;
`else
    assign bus.fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cur    <= '0;
            r_target <= '0;
            r_dir    <= 1'b1;
            r_pend   <= '0;
            r_door   <= 1'b0;
            r_start  <= 1'b0;
            r_delta  <= '0;
            r_dwell  <= '0;
`ifdef ELEVATOR_ACK_TIMEOUT_EN
            r_ack_cnt <= '0;
            r_fault   <= 1'b0;
`endif
        end else begin
            r_pend  <= (r_pend & ~w_clr) | w_set;
            r_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.open_btn || w_here) begin
                        r_state <= DOOR_OPEN;
                        r_door  <= 1'b1;
                        r_dwell <= DWELL_LOAD;
                    end else if (w_valid) begin
                        r_state  <= START;
                        r_start  <= 1'b1;
                        r_target <= w_target;
                        r_dir    <= w_new_dir;
                        r_delta  <= w_delta;
                    end
                end
                START: begin
                    r_state <= WAIT_ACK;
`ifdef ELEVATOR_ACK_TIMEOUT_EN
                    r_ack_cnt <= '0;
`endif
                end
                WAIT_ACK: begin
                    if (bus.move_busy) begin
                        r_state <= MOVING;
`ifdef ELEVATOR_ACK_TIMEOUT_EN
                    end else if (r_ack_cnt == ACK_LAST) begin
                        r_state <= FAULT;
                        r_fault <= 1'b1;
                        r_delta <= '0;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 1'b1;
`endif
                    end
                end
                MOVING: begin
                    if (!bus.move_busy) begin
                        r_cur   <= r_target;
                        r_state <= DOOR_OPEN;
                        r_door  <= 1'b1;
                        r_dwell <= DWELL_LOAD;
                    end
                end
                DOOR_OPEN: begin
                    if (bus.open_btn || w_reload) begin
                        r_dwell <= DWELL_LOAD;
                    end else if (bus.close_btn || r_dwell == '0) begin
                        r_door  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_dwell <= r_dwell - 1'b1;
                    end
                end
                FAULT:   r_door  <= 1'b0;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.move_start = r_start;
    assign bus.move_delta = r_delta;
    assign bus.door_open  = r_door;
    assign bus.cur_floor  = r_cur;
    assign bus.dir_up     = r_dir;
    assign bus.pending    = r_pend;

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: scoreboard bench; expected start/open events are
// queued with the stimulus and checked by an independent monitor.
`timescale 1ns/1ps
module tb_elevator_scheduler;

    localparam int NF     = 4;
    localparam int FW     = 2;
    localparam int DWELL  = 20;
    localparam int MOVE_T = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    elevator_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();
    elevator_scheduler_if #(.NUM_FLOORS(3), .FLOOR_W(FW)) bus3 ();

    elevator_scheduler #(
        .NUM_FLOORS   (NF),
        .FLOOR_W      (FW),
        .DWELL_CYCLES (DWELL)
`ifdef ELEVATOR_ACK_TIMEOUT_EN
       ,.ACK_TIMEOUT  (16)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    elevator_scheduler #(
        .NUM_FLOORS   (3),
        .FLOOR_W      (FW),
        .DWELL_CYCLES (DWELL)
    ) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    typedef struct {
        bit is_open;
        int val;
        bit dir;
        int len;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   motor_en = 1'b1;

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t ev_start(int delta, bit dir);
        exp_t e;
        e.is_open = 1'b0;
        e.val     = delta;
        e.dir     = dir;
        e.len     = 0;
        return e;
    endfunction

    function automatic exp_t ev_open(int floor, int len);
        exp_t e;
        e.is_open = 1'b1;
        e.val     = floor;
        e.dir     = 1'b0;
        e.len     = len;
        return e;
    endfunction

    task automatic chk_reset(string p);
        chk({p, "_cur"}, int'(bus.cur_floor), 0);
        chk({p, "_dir"}, int'(bus.dir_up), 1);
        chk({p, "_pend"}, int'(bus.pending), 0);
        chk({p, "_door"}, int'(bus.door_open), 0);
        chk({p, "_start"}, int'(bus.move_start), 0);
        chk({p, "_delta"}, int'(bus.move_delta), 0);
        chk({p, "_fault"}, int'(bus.fault), 0);
    endtask

    task automatic call(int f);
        bus.call_valid = 1'b1;
        bus.call_floor = FW'(f);
        @(negedge clk);
        bus.call_valid = 1'b0;
    endtask

    task automatic wait_door(string nm, int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.door_open) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL %s: door_open never rose within %0d cycles", nm, budget);
    endtask

    task automatic wait_busy(string nm, int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.move_busy) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL %s: move_busy never rose within %0d cycles", nm, budget);
    endtask

    task automatic drain(string nm, int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.door_open) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timeout with %0d events outstanding", nm, q.size());
    endtask

    // Simple motor driver: busy one cycle after start, for MOVE_T cycles.
    initial begin
        bus.move_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (motor_en && bus.move_start) begin
                @(negedge clk);
                bus.move_busy = 1'b1;
                repeat (MOVE_T) @(negedge clk);
                bus.move_busy = 1'b0;
            end
        end
    end

    initial begin : monitor
        bit   prev_door;
        int   cnt;
        int   exp_len;
        exp_t e;
        prev_door = 1'b0;
        cnt       = 0;
        exp_len   = 0;
        forever begin
            @(negedge clk);
            if (bus.move_start) begin
                chk("start_expected", int'(q.size() > 0 && !q[0].is_open), 1);
                if (q.size() > 0 && !q[0].is_open) begin
                    e = q.pop_front();
                    chk("start_delta", int'($signed(bus.move_delta)), e.val);
                    chk("start_dir", int'(bus.dir_up), int'(e.dir));
                end
                chk("interlock", int'({prev_door, bus.door_open}), 0);
            end
            if (bus.door_open && !prev_door) begin
                chk("open_expected", int'(q.size() > 0 && q[0].is_open), 1);
                if (q.size() > 0 && q[0].is_open) begin
                    e = q.pop_front();
                    chk("open_floor", int'(bus.cur_floor), e.val);
                    exp_len = e.len;
                end
                cnt = 0;
            end
            if (bus.door_open) cnt++;
            if (!bus.door_open && prev_door) chk("dwell_len", cnt, exp_len);
            prev_door = bus.door_open;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit start3;
        bus.call_valid  = 1'b0;
        bus.call_floor  = '0;
        bus.open_btn    = 1'b0;
        bus.close_btn   = 1'b0;
        bus3.call_valid = 1'b0;
        bus3.call_floor = '0;
        bus3.open_btn   = 1'b0;
        bus3.close_btn  = 1'b0;
        bus3.move_busy  = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("rst0");
        rst = 1'b0;

        // Single call: floor 0 -> 2.
        q.push_back(ev_start(2, 1'b1));
        q.push_back(ev_open(2, DWELL));
        call(2);
        drain("t1", 200);
        chk("t1_cur", int'(bus.cur_floor), 2);
        chk("t1_pend", int'(bus.pending), 0);

        // SCAN order from floor 1 going up with calls 0 and 3.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.push_back(ev_start(1, 1'b1));
        q.push_back(ev_open(1, DWELL));
        q.push_back(ev_start(2, 1'b1));
        q.push_back(ev_open(3, DWELL));
        q.push_back(ev_start(-3, 1'b0));
        q.push_back(ev_open(0, DWELL));
        call(1);
        wait_door("t2_open", 100);
        call(0);
        call(3);
        drain("t2", 600);
        chk("t2_cur", int'(bus.cur_floor), 0);
        chk("t2_dir", int'(bus.dir_up), 0);
        chk("t2_pend", int'(bus.pending), 0);

        // Open and close together on dwell cycle 10: open wins.
        q.push_back(ev_open(0, DWELL + 10));
        bus.open_btn = 1'b1;
        wait_door("t3_open", 10);
        bus.open_btn = 1'b0;
        repeat (9) @(negedge clk);
        bus.open_btn  = 1'b1;
        bus.close_btn = 1'b1;
        @(negedge clk);
        bus.open_btn  = 1'b0;
        bus.close_btn = 1'b0;
        drain("t3", 200);

        // Close alone on dwell cycle 3.
        q.push_back(ev_open(0, 3));
        bus.open_btn = 1'b1;
        wait_door("t3c_open", 10);
        bus.open_btn = 1'b0;
        repeat (2) @(negedge clk);
        bus.close_btn = 1'b1;
        @(negedge clk);
        bus.close_btn = 1'b0;
        drain("t3c", 50);

        // Buttons ignored while moving; call 1 queued and served after.
        q.push_back(ev_start(3, 1'b1));
        q.push_back(ev_open(3, DWELL));
        q.push_back(ev_start(-2, 1'b0));
        q.push_back(ev_open(1, DWELL));
        call(3);
        wait_busy("t4_busy", 20);
        bus.open_btn = 1'b1;
        @(negedge clk);
        bus.open_btn = 1'b0;
        chk("t4_door_moving", int'(bus.door_open), 0);
        call(1);
        chk("t4_pend_moving", int'(bus.pending), 4'b1010);
        drain("t4", 600);
        chk("t4_cur", int'(bus.cur_floor), 1);
        chk("t4_pend", int'(bus.pending), 0);

        // Call to the current floor opens; a repeat call extends the dwell.
        q.push_back(ev_open(1, DWELL + 5));
        call(1);
        wait_door("t5_open", 10);
        repeat (4) @(negedge clk);
        call(1);
        drain("t5", 200);
        chk("t5_pend", int'(bus.pending), 0);

        // Reset in the middle of a move.
        q.push_back(ev_start(2, 1'b1));
        call(3);
        wait_busy("t6_busy", 20);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("t6");
        rst = 1'b0;
        for (int i = 0; i < 20 && bus.move_busy; i++) @(negedge clk);
        @(negedge clk);
        chk("t6_door_after", int'(bus.door_open), 0);
        chk("t6_cur_after", int'(bus.cur_floor), 0);
        chk("t6_q_empty", q.size(), 0);

        // Three-floor build: floor 3 is out of range.
        bus3.call_valid = 1'b1;
        bus3.call_floor = 2'd3;
        @(negedge clk);
        bus3.call_valid = 1'b0;
        start3 = 1'b0;
        repeat (6) begin
            @(negedge clk);
            start3 = start3 | bus3.move_start;
        end
        chk("t7_oor_pend", int'(bus3.pending), 0);
        chk("t7_oor_start", int'(start3), 0);
        chk("t7_oor_door", int'(bus3.door_open), 0);
        bus3.call_valid = 1'b1;
        bus3.call_floor = 2'd2;
        @(negedge clk);
        bus3.call_valid = 1'b0;
        chk("t7_in_pend", int'(bus3.pending), 4);

`ifdef ELEVATOR_ACK_TIMEOUT_EN
        // Motor never acknowledges: fault after 16 WAIT_ACK cycles.
        motor_en = 1'b0;
        q.push_back(ev_start(2, 1'b1));
        call(2);
        @(negedge clk);
        repeat (16) @(negedge clk);
        chk("t8_fault_early", int'(bus.fault), 0);
        @(negedge clk);
        chk("t8_fault", int'(bus.fault), 1);
        chk("t8_delta", int'(bus.move_delta), 0);
        bus.open_btn = 1'b1;
        repeat (3) @(negedge clk);
        bus.open_btn = 1'b0;
        chk("t8_door", int'(bus.door_open), 0);
        chk("t8_fault_hold", int'(bus.fault), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("t8");
        rst = 1'b0;
        motor_en = 1'b1;
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Central controller for the elevator. Latches floor calls from the keypad into a pending-call mask and picks the next target floor with a SCAN policy (keep direction while calls remain ahead).
- Commands the motor driver with a one-cycle start pulse plus a signed floor delta, waits for its busy handshake, then runs the door-dwell sequence.
- Sits between the keypad decoder, open/close buttons, motor driver and door/display logic.

Parameters:
- NUM_FLOORS, 4, number of served floors; floor index 0..NUM_FLOORS-1, where index 0 is displayed as floor 1.
- FLOOR_W, 2, width of a floor index; must be >= clog2(NUM_FLOORS).
- DWELL_CYCLES, 300_000_000, door-open time in clk cycles (3 s at 100 MHz).
- ACK_TIMEOUT, 1_000_000, cycles to wait for motor busy to rise (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- call_valid  in  1  one-cycle strobe: a new floor call is present.
- call_floor  in  FLOOR_W  requested floor index; sampled when call_valid=1.
- open_btn  in  1  door-open request, level, already debounced.
- close_btn  in  1  door-close request, level, already debounced.
- move_busy  in  1  motor driver busy; 1 while travelling.
- move_start  out  1  one-cycle start pulse to the motor driver.
- move_delta  out  FLOOR_W+2  signed floors to travel (target - current); held stable from move_start until move_busy falls.
- door_open  out  1  door open command.
- cur_floor  out  FLOOR_W  current floor index.
- dir_up  out  1  SCAN direction; 1 = up.
- pending  out  NUM_FLOORS  pending-call mask.
- fault  out  1  sticky motor-ack timeout flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset values: state=IDLE, cur_floor=0, dir_up=1, pending=0, door_open=0, move_start=0, move_delta=0, fault=0.
- A reset asserted mid-move abandons the move; no resynchronisation with the motor is attempted.
- Call capture, every cycle, in every state:
  - call_valid with call_floor >= NUM_FLOORS: ignored.
  - Call to cur_floor while in DOOR_OPEN: reloads the dwell counter; the pending bit is not set.
  - Any other valid call sets pending[call_floor].
  - If a call sets the same bit that is cleared on arrival in the same cycle, the set wins. The call is then served again on the next IDLE pass.
- IDLE (door closed):
  - Priority 1: open_btn=1 or pending[cur_floor]=1 -> DOOR_OPEN; clear pending[cur_floor].
  - Priority 2: pending!=0 -> compute target and go to START.
  - Target rule: if dir_up and any pending above -> nearest above. Else if any pending below -> nearest below, dir_up<=0. Else nearest above, dir_up<=1. The symmetric rule applies when dir_up=0.
- START: move_start=1 for exactly one cycle; move_delta=target-cur_floor, sign-extended and never 0; -> WAIT_ACK.
- WAIT_ACK: wait for move_busy=1 -> MOVING.
- MOVING:
  - open_btn and close_btn are ignored; calls are still captured.
  - On move_busy falling: cur_floor<=target, clear pending[target], -> DOOR_OPEN. Latency from the busy fall to door_open=1 is 1 cycle.
- DOOR_OPEN:
  - door_open=1; the dwell counter loads DWELL_CYCLES-1 on entry and counts down.
  - open_btn=1: reloads the counter. It has priority over close_btn in the same cycle.
  - close_btn=1 with open_btn=0: ends dwell immediately.
  - At counter 0 or on close: door_open<=0, -> IDLE.
- Door-open interlock: door_open and move_start are never 1 in the same cycle. move_start is never asserted unless door_open was 0 in the previous cycle.
- Arithmetic: move_delta is computed in FLOOR_W+2 bits, two's complement; range ±(NUM_FLOORS-1).

Optional Feature:
- Macro: ELEVATOR_ACK_TIMEOUT_EN.
- With the macro defined:
  - WAIT_ACK counts cycles; if move_busy is not seen within ACK_TIMEOUT cycles: fault<=1, state -> FAULT, move_delta<=0.
  - FAULT holds door_open=0 and ignores buttons; calls are still latched into pending. Only rst exits FAULT.
- Without the macro: no counter is built, WAIT_ACK waits indefinitely, and fault is constant 0.

Decomposition:
- Shared package elevator_pkg holds:
  - the state enum: IDLE, START, WAIT_ACK, MOVING, DOOR_OPEN, FAULT;
  - NUM_FLOORS and FLOOR_W defaults;
  - the floor-index typedef and the signed delta typedef.
- One sub-module: scan_target_sel, purely combinational. Inputs: pending, cur_floor, dir_up. Outputs: target, new_dir, valid. It is verified standalone.

Test Plan:
- Reset, then call floor 2 at cur_floor 0:
  - move_start pulses once with move_delta=+2.
  - After move_busy 1→0: cur_floor=2, pending=0000, door_open=1 for DWELL_CYCLES cycles, then 0.
- SCAN order: at floor 1 with dir_up=1, calls 0 and 3 arrive together. Required sequence: delta +2 to floor 3, then delta -3 to floor 0 with dir_up=0.
- Dwell buttons:
  - Both pressed together at the 10th dwell cycle: open_btn wins, door stays open a further DWELL_CYCLES.
  - close_btn alone: door_open falls on the next cycle.
- During MOVING: open_btn is ignored (door_open stays 0); a new call to floor 1 sets pending[1]=1 and is served after arrival.
- Edge calls:
  - call_floor=cur_floor in IDLE opens the door without move_start.
  - Out-of-range call (NUM_FLOORS=3, floor 3) is ignored.
  - rst mid-MOVING returns all outputs to their reset values.
- With ELEVATOR_ACK_TIMEOUT_EN and ACK_TIMEOUT=16, move_busy held 0: fault=1 after 16 cycles in WAIT_ACK, buttons ignored, cleared only by rst.
